// File: rtl/spram_sweep_tester.sv
// Address sweeper for a single-port RAM: fills 0..DEPTH-1 with a seeded pattern, optionally reads back and counts mismatches.
// Optional macro SWEEP_CHECKER_EN: invert the pattern on odd addresses (checkerboard).
module spram_sweep_tester #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 10,
   parameter int DIV    = 10,
   parameter int RD_LAT = 1,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic              ram_we,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int                CTR_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CTR_W-1:0]  CTR_TOP = CTR_W'(DIV - 1);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                        state;
   logic [CTR_W-1:0]              ctr;
   logic                          tick;
   logic                          mode_q;
   logic [DATA_W-1:0]             seed_q;
   logic [ADDR_W-1:0]             addr_inc;
   logic [RD_LAT:1]               vld_pipe;
   logic [RD_LAT:1][DATA_W-1:0]   exp_pipe;
   logic                          mismatch;
   logic                          drain_ok;
   logic [ERR_W-1:0]              err_next;

   function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                             input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] p;
      p = s + DATA_W'(a);
`ifdef SWEEP_CHECKER_EN
      if (a[0]) p = ~p;
`endif
      return p;
   endfunction

   // Strobes decode registered state and counter so the access lands in the tick cycle itself.
   assign tick     = (ctr == CTR_TOP);
   assign ram_we   = (state == S_WRITE) && tick;
   assign ram_re   = (state == S_READ) && tick;
   assign addr_inc = ram_addr + ADDR_W'(1);

   always_comb begin
      mismatch = vld_pipe[RD_LAT] && (ram_rdata != exp_pipe[RD_LAT]);
      err_next = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
      // Ready to finish once only the stage being compared this cycle is still in flight.
      drain_ok = 1'b1;
      for (int k = 1; k < RD_LAT; k++)
         if (vld_pipe[k]) drain_ok = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ctr       <= '0;
         mode_q    <= 1'b0;
         seed_q    <= '0;
         vld_pipe  <= '0;
         exp_pipe  <= '0;
      end else begin
         done        <= 1'b0;
         err_count   <= err_next;
         vld_pipe[1] <= ram_re;
         exp_pipe[1] <= pat(seed_q, ram_addr);
         for (int k = 2; k <= RD_LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            exp_pipe[k] <= exp_pipe[k-1];
         end
         if (state == S_WRITE || state == S_READ)
            ctr <= tick ? '0 : ctr + CTR_W'(1);

         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  seed_q    <= seed;
                  err_count <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  ctr       <= '0;
                  ram_addr  <= '0;
                  ram_wdata <= pat(seed, '0);
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (tick) begin
                  if (ram_addr == LAST) begin
                     if (mode_q) begin
                        ram_addr <= '0;
                        state    <= S_READ;
                     end else begin
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= S_DONE;
                     end
                  end else begin
                     ram_addr  <= addr_inc;
                     ram_wdata <= pat(seed_q, addr_inc);
                  end
               end
            end
            S_READ: begin
               if (tick) begin
                  if (ram_addr == LAST) state <= S_DRAIN;
                  else                  ram_addr <= addr_inc;
               end
            end
            S_DRAIN: begin
               if (drain_ok) begin
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spram_sweep_tester.sv
// Scoreboard bench: three sweeper configurations, each with its own RAM model, expected-access queue and monitor.
module tb_spram_sweep_tester;

   logic clk = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   fin_cnt = 0;

   typedef struct { bit rd; int addr; int data; int cyc; } acc_t;
   typedef struct { int cyc; bit pass; int err; } res_t;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Reference pattern: seed plus address modulo 256, checkerboard-inverted on odd addresses when enabled.
   function automatic int pat(input int sd, input int a);
      int v;
      v = (sd + a) % 256;
`ifdef SWEEP_CHECKER_EN
      if (a % 2 == 1) v = 255 - v;
`endif
      return v;
   endfunction

   // Fault model: 1 = bit 0 flipped at one address, 2 = RAM reads stuck at zero.
   function automatic int fread(input int fm, input int fa, input int a, input int v);
      if (fm == 1 && a == fa) return v ^ 1;
      if (fm == 2) return 0;
      return v;
   endfunction

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : cfg
         localparam int AW = (g == 1) ? 9 : 4;
         localparam int DP = (g == 1) ? 300 : 10;
         localparam int DV = (g == 0) ? 10 : (g == 1) ? 1 : 3;
         localparam int RL = (g == 2) ? 3 : 1;

         logic          rst, start, mode, busy, done, pass, ram_we, ram_re;
         logic [7:0]    seed, err_count, ram_wdata, ram_rdata;
         logic [AW-1:0] ram_addr;
         logic [7:0]    mem [0:(1<<AW)-1];
         logic [7:0]    rp [1:RL];
         int            fmode = 0;
         int            faddr = 0;
         acc_t          exp_q[$];
         res_t          res_q[$];

         spram_sweep_tester #(.DATA_W(8), .ADDR_W(AW), .DEPTH(DP), .DIV(DV),
                              .RD_LAT(RL), .ERR_W(8)) dut (
            .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
            .busy(busy), .done(done), .pass(pass), .err_count(err_count),
            .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
            .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

         // RAM with RL-cycle read latency; non-read slots carry random junk to expose misaligned sampling.
         always @(posedge clk) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            rp[1] <= ram_re ? 8'(fread(fmode, faddr, int'(ram_addr), int'(mem[ram_addr])))
                            : 8'($urandom);
            for (int k = 2; k <= RL; k++) rp[k] <= rp[k-1];
         end
         assign ram_rdata = rp[RL];

         always @(negedge clk) begin : mon
            acc_t e;
            res_t r;
            if (ram_we || ram_re) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL cfg%0d stray_strobe: got we=%b re=%b addr=%0d required none", g, ram_we, ram_re, ram_addr);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("cfg%0d we", g), 32'(ram_we), 32'(!e.rd));
                  chk($sformatf("cfg%0d re", g), 32'(ram_re), 32'(e.rd));
                  chk($sformatf("cfg%0d addr", g), 32'(ram_addr), e.addr);
                  if (!e.rd) chk($sformatf("cfg%0d wdata", g), 32'(ram_wdata), e.data);
                  chk($sformatf("cfg%0d access_cycle", g), cyc, e.cyc);
               end
            end
            if (done) begin
               if (res_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL cfg%0d stray_done: got done at cycle %0d required none", g, cyc);
               end else begin
                  r = res_q.pop_front();
                  chk($sformatf("cfg%0d done_cycle", g), cyc, r.cyc);
                  chk($sformatf("cfg%0d pass", g), 32'(pass), 32'(r.pass));
                  chk($sformatf("cfg%0d err_count", g), 32'(err_count), r.err);
                  chk($sformatf("cfg%0d busy_in_done", g), 32'(busy), 1);
               end
            end
         end

         task automatic reset_chk();
            rst = 1'b1; start = 1'b0; mode = 1'b0; seed = 8'h00;
            repeat (3) @(negedge clk);
            chk($sformatf("cfg%0d rst_busy", g), 32'(busy), 0);
            chk($sformatf("cfg%0d rst_done", g), 32'(done), 0);
            chk($sformatf("cfg%0d rst_pass", g), 32'(pass), 0);
            chk($sformatf("cfg%0d rst_err", g), 32'(err_count), 0);
            chk($sformatf("cfg%0d rst_we", g), 32'(ram_we), 0);
            chk($sformatf("cfg%0d rst_re", g), 32'(ram_re), 0);
            chk($sformatf("cfg%0d rst_addr", g), 32'(ram_addr), 0);
            chk($sformatf("cfg%0d rst_wdata", g), 32'(ram_wdata), 0);
            rst = 1'b0;
         endtask

         task automatic run(input bit m, input int sd, input int fm, input int fa, input bit dbl);
            int s, nerr, dcyc, t;
            fmode = fm; faddr = fa; nerr = 0;
            @(negedge clk);
            s = cyc;
            start = 1'b1; mode = m; seed = 8'(sd);
            for (int a = 0; a < DP; a++)
               exp_q.push_back('{0, a, pat(sd, a), s + DV * (a + 1)});
            if (m) begin
               for (int a = 0; a < DP; a++) begin
                  exp_q.push_back('{1, a, pat(sd, a), s + DV * (DP + a + 1)});
                  if (fread(fm, fa, a, pat(sd, a)) != pat(sd, a)) nerr++;
               end
            end
            dcyc = m ? s + 2 * DV * DP + RL + 1 : s + DV * DP + 1;
            res_q.push_back('{dcyc, nerr == 0, (nerr > 255) ? 255 : nerr});
            @(negedge clk);
            start = 1'b0; mode = ~m; seed = ~seed;
            chk($sformatf("cfg%0d busy_after_start", g), 32'(busy), 1);
            chk($sformatf("cfg%0d err_cleared", g), 32'(err_count), 0);
            chk($sformatf("cfg%0d pass_cleared", g), 32'(pass), 0);
            if (dbl) begin
               @(negedge clk); start = 1'b1;
               @(negedge clk); start = 1'b0;
            end
            t = 0;
            while (res_q.size() != 0 && t < dcyc - s + 20) begin
               @(negedge clk); t++;
            end
            if (res_q.size() != 0) begin
               total++; bad++;
               $display("FAIL cfg%0d done_timeout: got no done required by cycle %0d", g, dcyc);
               exp_q.delete(); res_q.delete();
            end
            @(negedge clk);
            chk($sformatf("cfg%0d busy_after_done", g), 32'(busy), 0);
            chk($sformatf("cfg%0d pass_held", g), 32'(pass), 32'(nerr == 0));
            chk($sformatf("cfg%0d err_held", g), 32'(err_count), (nerr > 255) ? 255 : nerr);
            chk($sformatf("cfg%0d accesses_left", g), exp_q.size(), 0);
         endtask

         // Reset lands during the third write tick; nothing may follow it.
         task automatic rst_mid(input int sd);
            int s;
            fmode = 0;
            @(negedge clk);
            s = cyc;
            start = 1'b1; mode = 1'b1; seed = 8'(sd);
            for (int a = 0; a < 3; a++)
               exp_q.push_back('{0, a, pat(sd, a), s + DV * (a + 1)});
            @(negedge clk);
            start = 1'b0;
            while (cyc < s + 3 * DV) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk($sformatf("cfg%0d midrst_busy", g), 32'(busy), 0);
            chk($sformatf("cfg%0d midrst_we", g), 32'(ram_we), 0);
            chk($sformatf("cfg%0d midrst_addr", g), 32'(ram_addr), 0);
            chk($sformatf("cfg%0d midrst_err", g), 32'(err_count), 0);
            chk($sformatf("cfg%0d midrst_pending", g), exp_q.size(), 0);
            repeat (3 * DV) @(negedge clk);
         endtask

         initial begin
            reset_chk();
            case (g)
               0: begin
                  run(1'b0, 8'h00, 0, 0, 1'b0);
                  run(1'b1, 8'hF8, 0, 0, 1'b0);
                  run(1'b1, $urandom_range(255), 1, 5, 1'b0);
                  rst_mid($urandom_range(255));
                  run(1'b1, $urandom_range(255), 0, 0, 1'b0);
               end
               1: begin
                  run(1'b1, 8'h00, 2, 0, 1'b0);
                  run(1'b1, $urandom_range(255), 0, 0, 1'b0);
               end
               default: begin
                  run(1'b1, 8'h00, 0, 0, 1'b1);
                  run(1'b1, $urandom_range(255), 1, $urandom_range(DP - 1), 1'b1);
               end
            endcase
            for (int i = 0; i < 3; i++)
               run(1'($urandom_range(1)), $urandom_range(255), $urandom_range(2),
                   $urandom_range(DP - 1), 1'($urandom_range(1)));
            fin_cnt++;
         end
      end
   endgenerate

   initial begin
      for (int t = 0; t < 30000 && fin_cnt < 3; t++) @(posedge clk);
      if (fin_cnt < 3) begin
         total++; bad++;
         $display("FAIL global_timeout: got %0d configs finished required 3", fin_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spram_sweep_tester.md
Name: spram_sweep_tester

Overview:
Parametrised successor to the free-running address sweeper that feeds the inferred single-port RAM.
- Sweeps addresses 0..DEPTH-1 at a programmable tick rate, writing a seeded pattern into the RAM.
- Optionally reads every location back and checks it against the same pattern.
- Reports busy/done/pass and a saturating error count.
- Sits between board-level control (buttons, host register) and one single-port RAM instance, all on one clock.

Parameters:
DATA_W, 8, RAM data width
ADDR_W, 4, RAM address width
DEPTH, 10, locations swept (2 ≤ DEPTH ≤ 2^ADDR_W)
DIV, 10, clk cycles per RAM access tick (DIV ≥ 1; 1 = every cycle)
RD_LAT, 1, RAM read latency in cycles (1..4)
ERR_W, 8, error counter width

Ports:
clk  in  1  system clock; everything is on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = fill only, 1 = fill then verify; latched on start
seed  in  DATA_W  pattern seed; latched on start
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse in DONE
pass  out  1  valid from done until next start; 1 when err_count == 0
err_count  out  ERR_W  mismatch count, saturating at all-ones; cleared on start
ram_we  out  1  write strobe, one clk wide per write tick
ram_re  out  1  read strobe, one clk wide per read tick
ram_addr  out  ADDR_W  registered address; held between ticks
ram_wdata  out  DATA_W  registered write data
ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset values: busy=0, done=0, pass=0, err_count=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0. State=IDLE, divider=0, compare pipeline cleared.
- Tick divider:
  - Counter cleared on start acceptance.
  - tick = (ctr == DIV-1); counter wraps to 0 on tick.
  - First access occurs DIV cycles after the start cycle.
- Pattern: P(a) = (seed + a) mod 2^DATA_W, with a zero-extended.
- States:
  - IDLE: if start, latch mode and seed, clear err_count and pass, go to WRITE with addr=0. Otherwise stay.
  - WRITE: on tick, assert ram_we for one cycle with ram_addr=a and ram_wdata=P(a). If a == DEPTH-1: go to DONE when mode=0, or to READ with a=0 when mode=1. Otherwise a+1.
  - READ: on tick, assert ram_re for one cycle with ram_addr=a, and push {valid, P(a)} into an RD_LAT-deep pipeline. After a == DEPTH-1, go to DRAIN.
  - DRAIN: wait until the pipeline is empty (RD_LAT cycles after the last ram_re), then go to DONE.
  - DONE: done=1 for one cycle; pass=(err_count==0); busy falls in the next cycle; return to IDLE.
- Compare: ram_rdata is sampled exactly RD_LAT cycles after the cycle ram_re was high. On mismatch, err_count increments unless it is already all-ones.
- ram_we and ram_re are never high in the same cycle. Both are 0 outside their tick cycles.
- start while busy is ignored. No queueing.
- rst mid-operation: next cycle all outputs return to reset values and any in-flight compare is discarded.
- DIV=1: accesses are back-to-back. The READ→DRAIN→DONE sequence still honours RD_LAT.

Optional Feature:
SWEEP_CHECKER_EN
- Defined: P(a) is bitwise inverted for odd a (checkerboard). Applies to both write data and expected data.
- Undefined: P(a) = seed + a for all a. No inversion logic is present.

Test Plan:
- DEPTH=10, DIV=10, seed=0x00, mode=0, start pulse → exactly 10 ram_we pulses, the first 10 cycles after start, then every 10 cycles; addr/wdata 0/0x00 .. 9/0x09; no ram_re; done pulse; pass=1, err_count=0.
- Same, mode=1, ideal RAM model RD_LAT=1, seed=0xF8 → writes of 0xF8..0xFF,0x00,0x01 (wrap); 10 reads; pass=1, err_count=0; done 1 cycle after the last read compare.
- mode=1, RAM model flips bit 0 at addr 5 → err_count=1, pass=0.
- DEPTH=300, ADDR_W=9, DIV=1, seed=0, RAM returns stuck-at-0x00 → 298 mismatches; err_count saturates at 0xFF; pass=0.
- rst asserted during the 3rd write tick → next cycle busy=0, ram_we=0, ram_addr=0. New start restarts at addr 0 with err_count=0.
- start pulsed again while busy, and with RD_LAT=3 → second start ignored; compare aligned 3 cycles after each ram_re; pass=1. With SWEEP_CHECKER_EN and seed=0, addr 1 written as 0xFE.
